// File: rtl/tlb_mport.sv
`default_nettype none
// ============================================================================
// Module   : tlb_mport
// Brief    : Fully associative multi-port TLB with registered lookups, write,
//            read and search ports, and an entry-by-entry INVTLB sweep FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_mport #(
    parameter int TLBNUM = 32,
    parameter int NPORT  = 2,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NPORT-1:0]     t_en,
    input  logic [32*NPORT-1:0]  t_vaddr,
    input  logic [10*NPORT-1:0]  t_asid,
    input  logic [2*NPORT-1:0]   t_plv,
    input  logic [2*NPORT-1:0]   t_type,
    output logic [NPORT-1:0]     o_valid,
    output logic [32*NPORT-1:0]  o_paddr,
    output logic [2*NPORT-1:0]   o_mat,
    output logic [6*NPORT-1:0]   o_excp,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [IDXW-1:0]      w_index,
    input  logic [88:0]          w_entry,
    input  logic [IDXW-1:0]      r_index,
    output logic [88:0]          r_entry,
    input  logic [18:0]          s_vpn2,
    input  logic [9:0]           s_asid,
    output logic                 s_hit,
    output logic [IDXW-1:0]      s_index,
    input  logic                 inv_valid,
    output logic                 inv_ready,
    input  logic [2:0]           inv_op,
    input  logic [9:0]           inv_asid,
    input  logic [18:0]          inv_vpn2,
    output logic                 inv_busy,
    output logic                 inv_done
);

    localparam logic [1:0]      c_S_IDLE  = 2'd0;
    localparam logic [1:0]      c_S_SWEEP = 2'd1;
    localparam logic [1:0]      c_S_DONE  = 2'd2;
    localparam logic [IDXW-1:0] c_LAST    = IDXW'(TLBNUM - 1);

    // Only the E bits need reset; the payload is qualified by E everywhere.
    logic [TLBNUM-1:0] r_e;
    logic [87:0]       r_data [TLBNUM];
    logic [18:0]       w_vpn2 [TLBNUM];
    logic [9:0]        w_asid [TLBNUM];
    logic [5:0]        w_ps   [TLBNUM];
    logic [TLBNUM-1:0] w_g;

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic [9:0]      r_inv_asid;
    logic [18:0]     r_inv_vpn2;
    logic            r_inv_done;
    logic            w_fire;
    logic            w_inv_hit;

    function automatic logic vpn_hit(input logic [5:0] ps, input logic [18:0] vpn2,
                                     input logic [18:0] va_vpn2);
        return ((ps == 6'd12) && (vpn2 == va_vpn2)) ||
               ((ps == 6'd21) && (vpn2[18:9] == va_vpn2[18:9]));
    endfunction

    for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
        assign w_vpn2[i] = r_data[i][87:69];
        assign w_asid[i] = r_data[i][68:59];
        assign w_ps[i]   = r_data[i][58:53];
        assign w_g[i]    = r_data[i][52];
    end

    assign w_ready   = (r_state == c_S_IDLE);
    assign inv_ready = (r_state == c_S_IDLE);
    assign inv_busy  = (r_state != c_S_IDLE);
    assign inv_done  = r_inv_done;
    assign w_fire    = w_valid && w_ready;
    assign r_entry   = {r_e[r_index], r_data[r_index]};

    always_comb begin
        w_inv_hit = 1'b0;
        case (r_op)
            3'd0, 3'd1: w_inv_hit = 1'b1;
            3'd2:       w_inv_hit = w_g[r_cnt];
            3'd3:       w_inv_hit = !w_g[r_cnt];
            3'd4:       w_inv_hit = !w_g[r_cnt] && (w_asid[r_cnt] == r_inv_asid);
            3'd5:       w_inv_hit = !w_g[r_cnt] && (w_asid[r_cnt] == r_inv_asid) &&
                                    vpn_hit(w_ps[r_cnt], w_vpn2[r_cnt], r_inv_vpn2);
            3'd6:       w_inv_hit = (w_g[r_cnt] || (w_asid[r_cnt] == r_inv_asid)) &&
                                    vpn_hit(w_ps[r_cnt], w_vpn2[r_cnt], r_inv_vpn2);
            default:    w_inv_hit = 1'b0;
        endcase
    end

    // Writes only happen in IDLE and clears only in SWEEP, so they never collide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_e <= '0;
        end else begin
            if (w_fire)
                r_e[w_index] <= w_entry[88];
            if ((r_state == c_S_SWEEP) && w_inv_hit)
                r_e[r_cnt] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire)
            r_data[w_index] <= w_entry[87:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_inv_asid <= '0;
            r_inv_vpn2 <= '0;
            r_inv_done <= 1'b0;
        end else begin
            r_inv_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (inv_valid) begin
                        r_state    <= c_S_SWEEP;
                        r_cnt      <= '0;
                        r_op       <= inv_op;
                        r_inv_asid <= inv_asid;
                        r_inv_vpn2 <= inv_vpn2;
                    end
                end
                c_S_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST)
                        r_state <= c_S_DONE;
                end
                c_S_DONE: begin
                    r_state    <= c_S_IDLE;
                    r_inv_done <= 1'b1;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Descending scan so the lowest hitting index is the last one assigned.
    always_comb begin
        s_hit   = 1'b0;
        s_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (r_e[i] && (w_g[i] || (w_asid[i] == s_asid)) && vpn_hit(w_ps[i], w_vpn2[i], s_vpn2)) begin
                s_hit   = 1'b1;
                s_index = IDXW'(i);
            end
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [31:0]     w_va;
        logic [9:0]      w_tasid;
        logic [1:0]      w_tplv;
        logic [1:0]      w_ttype;
        logic            w_hit;
        logic [IDXW-1:0] w_idx;
        logic            w_big;
        logic            w_odd;
        logic [19:0]     w_pfn;
        logic [1:0]      w_mat;
        logic [1:0]      w_plv;
        logic            w_d;
        logic            w_v;
        logic [31:0]     w_paddr;
        logic [5:0]      w_excp;
        logic            r_valid;
        logic [31:0]     r_paddr;
        logic [1:0]      r_mat;
        logic [5:0]      r_excp;

        assign w_va    = t_vaddr[32*p +: 32];
        assign w_tasid = t_asid[10*p +: 10];
        assign w_tplv  = t_plv[2*p +: 2];
        assign w_ttype = t_type[2*p +: 2];

        always_comb begin
            w_hit = 1'b0;
            w_idx = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (r_e[i] && (w_g[i] || (w_asid[i] == w_tasid)) && vpn_hit(w_ps[i], w_vpn2[i], w_va[31:13])) begin
                    w_hit = 1'b1;
                    w_idx = IDXW'(i);
                end
            end
        end

        assign w_big   = (w_ps[w_idx] == 6'd21);
        assign w_odd   = w_big ? w_va[21] : w_va[12];
        assign w_pfn   = w_odd ? r_data[w_idx][25:6]  : r_data[w_idx][51:32];
        assign w_mat   = w_odd ? r_data[w_idx][5:4]   : r_data[w_idx][31:30];
        assign w_plv   = w_odd ? r_data[w_idx][3:2]   : r_data[w_idx][29:28];
        assign w_d     = w_odd ? r_data[w_idx][1]     : r_data[w_idx][27];
        assign w_v     = w_odd ? r_data[w_idx][0]     : r_data[w_idx][26];
        assign w_paddr = w_big ? {w_pfn[19:9], w_va[20:0]} : {w_pfn, w_va[11:0]};

        always_comb begin
            w_excp = 6'b000000;
            if (!w_hit)
                w_excp = 6'b000001;
            else if (!w_v) begin
                case (w_ttype)
                    2'd1:    w_excp = 6'b000100;
                    2'd2:    w_excp = 6'b001000;
                    default: w_excp = 6'b000010;
                endcase
            end else if (w_tplv > w_plv)
                w_excp = 6'b010000;
            else if ((w_ttype == 2'd1) && !w_d)
                w_excp = 6'b100000;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_valid <= 1'b0;
                r_paddr <= '0;
                r_mat   <= '0;
                r_excp  <= '0;
            end else if (t_en[p]) begin
                r_valid <= 1'b1;
                r_excp  <= w_excp;
                r_paddr <= (w_excp == 6'd0) ? w_paddr : 32'd0;
                r_mat   <= (w_excp == 6'd0) ? w_mat : 2'd0;
            end
        end

        assign o_valid[p]          = r_valid;
        assign o_paddr[32*p +: 32] = r_paddr;
        assign o_mat[2*p +: 2]     = r_mat;
        assign o_excp[6*p +: 6]    = r_excp;
    end

endmodule
`default_nettype wire
